// File: rtl/run_ctrl_gen.sv
// Run/halt sequencer: starts the core on a start edge and ends the run on a halt opcode, abort or watchdog.
// Outputs come straight from flops; every transition takes effect one cycle after the input that causes it.
module run_ctrl_gen #(
   parameter int              INSTR_W     = 32,
   parameter                  HALT_OP0    = 32'h00000073,
   parameter                  HALT_OP1    = 32'h00100073,
   parameter int              CNT_W       = 32,
   parameter longint unsigned TIMEOUT_CYC = 0,
   parameter bit              DONE_PULSE  = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_in,
   input  logic               abort_in,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               done_ack,
   output logic               run_en,
   output logic               busy,
   output logic               done_o,
   output logic               fault_o,
   output logic               timeout_o,
   output logic [1:0]         halt_cause,
   output logic [CNT_W-1:0]   cycle_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_DONE  = 2'b10,
      S_FAULT = 2'b11
   } state_t;

   localparam logic [INSTR_W-1:0] OP0    = INSTR_W'(HALT_OP0);
   localparam logic [INSTR_W-1:0] OP1    = INSTR_W'(HALT_OP1);
   localparam logic [CNT_W:0]     TO_LIM = (CNT_W+1)'(TIMEOUT_CYC);
   localparam bit                 TO_EN  = (TIMEOUT_CYC != 0);

   state_t             state_q;
   state_t             state_d;
   logic               start_q;
   logic               start_edge;
   logic [CNT_W:0]     cnt_inc;
   logic [CNT_W-1:0]   cnt_sat;
   logic [CNT_W-1:0]   cnt_d;
   logic [1:0]         cause_d;
   logic               to_d;
   logic               hit0;
   logic               hit1;
   logic               to_hit;

   assign start_edge = start_in & ~start_q;
   assign hit0       = instr_valid && (instr_in == OP0);
   assign hit1       = instr_valid && (instr_in == OP1);

   // The widened increment lets the watchdog compare against the full limit
   // even when the counter itself is about to saturate.
   assign cnt_inc = {1'b0, cycle_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign cnt_sat = (&cycle_cnt) ? cycle_cnt : cnt_inc[CNT_W-1:0];
   assign to_hit  = TO_EN && (cnt_inc == TO_LIM);

   always_comb begin
      state_d = state_q;
      cnt_d   = cycle_cnt;
      cause_d = halt_cause;
      to_d    = timeout_o;
      case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               state_d = S_RUN;
               cnt_d   = '0;
               cause_d = 2'b00;
               to_d    = 1'b0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_sat;
            if (abort_in) begin
               state_d = S_FAULT;
               cause_d = 2'b11;
               to_d    = 1'b0;
            end else if (hit0) begin
               state_d = S_DONE;
               cause_d = 2'b01;
            end else if (hit1) begin
               state_d = S_DONE;
               cause_d = 2'b10;
            end else if (to_hit) begin
               state_d = S_FAULT;
               cause_d = 2'b11;
               to_d    = 1'b1;
            end
         end
         S_DONE, S_FAULT: begin
            if (DONE_PULSE || done_ack) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         cycle_cnt  <= '0;
         halt_cause <= 2'b00;
         timeout_o  <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_in;
         cycle_cnt  <= cnt_d;
         halt_cause <= cause_d;
         timeout_o  <= to_d;
      end
   end

   assign run_en  = (state_q == S_RUN);
   assign busy    = (state_q != S_IDLE);
   assign done_o  = (state_q == S_DONE);
   assign fault_o = (state_q == S_FAULT);

endmodule

// File: doc/run_ctrl_gen.md
Name: run_ctrl_gen

Overview:
Parametrised run/halt sequencer for the RV32 core. It launches execution on a start edge and watches the retiring instruction stream for configurable halt opcodes (ECALL, EBREAK). It also supports abort, an optional watchdog timeout, a run-cycle counter, and a selectable done signalling mode (held-until-ack or single pulse). It sits between the host/top-level control and the core's run enable.

Parameters:
INSTR_W, 32, width of the instruction word monitored.
HALT_OP0, 32'h00000073, first halt opcode (ECALL); cause code 2'b01.
HALT_OP1, 32'h00100073, second halt opcode (EBREAK); cause code 2'b10.
CNT_W, 32, width of the run-cycle counter.
TIMEOUT_CYC, 0, watchdog limit in RUN cycles; 0 disables the watchdog.
DONE_PULSE, 0, 0 means done/fault held until done_ack; 1 means a one-cycle pulse with automatic return to IDLE.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
start_in  in  1  start request; only a 0->1 edge is acted on.
abort_in  in  1  forces RUN to end as a fault.
instr_valid  in  1  instr_in is a retiring instruction this cycle.
instr_in  in  INSTR_W  retiring instruction word.
done_ack  in  1  host acknowledge of done/fault (used only when DONE_PULSE=0).
run_en  out  1  core run enable; high only in RUN.
busy  out  1  high when state is not IDLE.
done_o  out  1  run ended normally (halt opcode seen).
fault_o  out  1  run ended by abort or timeout.
timeout_o  out  1  qualifies fault_o: 1 means watchdog, 0 means abort.
halt_cause  out  2  00 none, 01 HALT_OP0, 10 HALT_OP1, 11 abort/timeout.
cycle_cnt  out  CNT_W  number of RUN cycles in the last or current run.

Behaviour:
- Reset (asynchronous, rst=0): state=IDLE, start_q=0, all outputs 0, cycle_cnt=0.
- All outputs are registered. run_en, busy, done_o and fault_o decode from the state register.
- Start edge: start_edge = start_in & ~start_q, where start_q is a registered copy of start_in.
  - start_in high in the first cycle after reset counts as an edge.
- State encoding: IDLE=00, RUN=01, DONE=10, FAULT=11.
- IDLE:
  - On start_edge: go to RUN next cycle; cycle_cnt<=0; halt_cause<=00; timeout_o<=0.
  - abort_in, instr_valid and done_ack are ignored.
- RUN:
  - cycle_cnt<=cycle_cnt+1 on every RUN cycle, saturating at all-ones.
  - Per-cycle transition priority, highest first:
    1. abort_in=1: go to FAULT; halt_cause=11; timeout_o=0.
    2. instr_valid & instr_in==HALT_OP0: go to DONE; halt_cause=01.
    3. instr_valid & instr_in==HALT_OP1: go to DONE; halt_cause=10.
    4. TIMEOUT_CYC!=0 & cycle_cnt+1==TIMEOUT_CYC: go to FAULT; halt_cause=11; timeout_o=1.
  - The terminating cycle still increments cycle_cnt. After k RUN cycles, cycle_cnt=k.
  - start_edge in RUN is ignored.
  - An opcode with instr_valid=0 is never matched.
  - If HALT_OP0==HALT_OP1, cause 01 wins.
- DONE / FAULT:
  - run_en=0. cycle_cnt and halt_cause are frozen.
  - DONE_PULSE=0: done_o or fault_o stays high until done_ack=1, then return to IDLE next cycle. halt_cause and cycle_cnt are held in IDLE until the next start.
  - DONE_PULSE=1: done_o or fault_o is high for exactly one cycle, then automatic return to IDLE. done_ack is ignored.
  - A start_edge in DONE/FAULT is not latched. A new run requires a fresh edge while in IDLE.
- Reset mid-RUN: immediate return to IDLE with all outputs cleared. No done or fault is reported.
- Width rules:
  - Opcode compare is the full INSTR_W bits.
  - HALT_OPx are truncated or zero-extended to INSTR_W.
  - TIMEOUT_CYC must be < 2^CNT_W.

Test Plan:
- Defaults. Pulse start_in, then present instr_valid=1 with 32'h00000013 for 4 cycles and 32'h00000073 on the 5th RUN cycle -> run_en high for 5 cycles; done_o=1; halt_cause=01; cycle_cnt=5; done_o held until done_ack, then IDLE.
- EBREAK 32'h00100073 on RUN cycle 3 -> halt_cause=10; cycle_cnt=3. ECALL presented with instr_valid=0 -> no halt.
- TIMEOUT_CYC=10, no halt -> fault_o=1; timeout_o=1; halt_cause=11; cycle_cnt=10. Halt on RUN cycle 10 together with timeout -> DONE with halt_cause=01.
- abort_in and ECALL in the same RUN cycle -> FAULT; timeout_o=0; halt_cause=11. abort_in in IDLE -> no state change.
- DONE_PULSE=1 -> done_o high for exactly 1 cycle, then busy=0. start_in held high across the run -> no second run until start_in goes 0 then 1.
- rst asserted on RUN cycle 2 -> run_en, busy and cycle_cnt all 0 immediately; no done_o or fault_o after release.
